// File: rtl/arb_pkg.sv
// Shared types and helpers for the memory request arbiter.
// Holds the FSM state encoding, the default widths and the channel-id width helper.
package arb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } arb_state_t;

    // A single-channel configuration still needs a one-bit id.
    function automatic int ch_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_grant_picker.sv
// Combinational winner selection: round-robin starting at rr_ptr, or lowest-index-first.
module arb_grant_picker
    import arb_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int CH_ID_W = ch_id_w(N_CH)
) (
    input  logic [N_CH-1:0]    req,
    input  logic [CH_ID_W-1:0] rr_ptr,
    input  logic               rr_mode,
    output logic [CH_ID_W-1:0] winner,
    output logic               any_valid
);

    int   idx;
    logic found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < N_CH; i++) begin
            // Round-robin walks upward from rr_ptr and wraps past the last channel.
            idx = rr_mode ? ((int'(rr_ptr) + i) % N_CH) : i;
            if (!found && req[idx]) begin
                winner = CH_ID_W'(idx);
                found  = 1'b1;
            end
        end
        any_valid = found;
    end

endmodule

// File: rtl/mem_request_arbiter.sv
// N-channel memory-port arbiter: grants one requester, drives the port from latched
// fields until the memory completes, then pulses that channel's ack for one cycle.
module mem_request_arbiter
    import arb_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int N_CH    = 2,
    parameter int RR_MODE = 1
) (
    input  logic                             clk,
    input  logic                             nRst,
    input  logic [N_CH-1:0]                  ch_req,
    input  logic [N_CH-1:0]                  ch_we,
    input  logic [N_CH-1:0][DATA_W/8-1:0]    ch_sel,
    input  logic [N_CH-1:0][ADDR_W-1:0]      ch_adr,
    input  logic [N_CH-1:0][DATA_W-1:0]      ch_wdata,
    output logic [N_CH-1:0]                  ch_ack,
    output logic [N_CH-1:0][DATA_W-1:0]      ch_rdata,
    output logic                             mem_read,
    output logic                             mem_write,
    output logic [DATA_W/8-1:0]              mem_sel,
    output logic [ADDR_W-1:0]                mem_adr,
    output logic [DATA_W-1:0]                mem_wdata,
    input  logic                             mem_busy,
    input  logic [DATA_W-1:0]                mem_rdata,
    output logic [ch_id_w(N_CH)-1:0]         grant_id
);

    localparam int CH_ID_W = ch_id_w(N_CH);
    localparam int SEL_W   = DATA_W / 8;

    arb_state_t           state;
    logic [CH_ID_W-1:0]   rr_ptr;
    logic [CH_ID_W-1:0]   pick;
    logic                 pick_valid;
    logic                 lat_we;
    logic [SEL_W-1:0]     lat_sel;
    logic [ADDR_W-1:0]    lat_adr;
    logic [DATA_W-1:0]    lat_wdata;
    logic [CH_ID_W-1:0]   next_ptr;

    arb_grant_picker #(
        .N_CH    (N_CH),
        .CH_ID_W (CH_ID_W)
    ) u_picker (
        .req       (ch_req),
        .rr_ptr    (rr_ptr),
        .rr_mode   (RR_MODE != 0),
        .winner    (pick),
        .any_valid (pick_valid)
    );

    assign next_ptr = (grant_id == CH_ID_W'(N_CH - 1)) ? '0 : grant_id + CH_ID_W'(1);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            lat_we    <= 1'b0;
            lat_sel   <= '0;
            lat_adr   <= '0;
            lat_wdata <= '0;
            ch_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_id  <= pick;
                        lat_we    <= ch_we[pick];
                        lat_sel   <= ch_sel[pick];
                        lat_adr   <= ch_adr[pick];
                        lat_wdata <= ch_wdata[pick];
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (!mem_busy) begin
                        if (!lat_we) begin
                            ch_rdata[grant_id] <= mem_rdata;
                        end
                        state <= ACK;
                    end
                end
                ACK: begin
                    if (RR_MODE != 0) begin
                        rr_ptr <= next_ptr;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Port command is decoded from state so a reset removes it without waiting for a clock.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_sel   = '0;
        mem_adr   = '0;
        mem_wdata = '0;
        ch_ack    = '0;
        if (state == BUSY) begin
            mem_read  = ~lat_we;
            mem_write = lat_we;
            mem_sel   = lat_sel;
            mem_adr   = lat_adr;
            mem_wdata = lat_wdata;
        end
        if (state == ACK) begin
            ch_ack[grant_id] = 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench: a cycle table for single transactions plus sequences for reset,
// round-robin contention and fixed-priority contention on two 3-channel instances.
module tb_mem_request_arbiter;

    localparam int NC = 3;

    logic              clk;
    logic              nRst;
    logic [NC-1:0]     req_a, req_b;
    logic [NC-1:0]     we;
    logic [NC-1:0][3:0]  sel;
    logic [NC-1:0][31:0] adr;
    logic [NC-1:0][31:0] wdata;
    logic              mem_busy;
    logic [31:0]       mem_rdata;

    logic [NC-1:0]       ack_a, ack_b;
    logic [NC-1:0][31:0] rdata_a, rdata_b;
    logic                rd_a, wr_a, rd_b, wr_b;
    logic [3:0]          msel_a, msel_b;
    logic [31:0]         madr_a, madr_b, mwd_a, mwd_b;
    logic [1:0]          gid_a, gid_b;

    int checks = 0;
    int errors = 0;

    mem_request_arbiter #(.DATA_W(32), .ADDR_W(32), .N_CH(NC), .RR_MODE(1)) dut_rr (
        .clk(clk), .nRst(nRst), .ch_req(req_a), .ch_we(we), .ch_sel(sel), .ch_adr(adr),
        .ch_wdata(wdata), .ch_ack(ack_a), .ch_rdata(rdata_a), .mem_read(rd_a),
        .mem_write(wr_a), .mem_sel(msel_a), .mem_adr(madr_a), .mem_wdata(mwd_a),
        .mem_busy(mem_busy), .mem_rdata(mem_rdata), .grant_id(gid_a)
    );

    mem_request_arbiter #(.DATA_W(32), .ADDR_W(32), .N_CH(NC), .RR_MODE(0)) dut_fp (
        .clk(clk), .nRst(nRst), .ch_req(req_b), .ch_we(we), .ch_sel(sel), .ch_adr(adr),
        .ch_wdata(wdata), .ch_ack(ack_b), .ch_rdata(rdata_b), .mem_read(rd_b),
        .mem_write(wr_b), .mem_sel(msel_b), .mem_adr(madr_b), .mem_wdata(mwd_b),
        .mem_busy(mem_busy), .mem_rdata(mem_rdata), .grant_id(gid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  req;
        int          ch;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        busy;
        logic [31:0] rd;
        logic        e_rd;
        logic        e_wr;
        logic [3:0]  e_sel;
        logic [31:0] e_adr;
        logic [31:0] e_wd;
        logic [2:0]  e_ack;
        logic [1:0]  e_gid;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Target channel gets the row's fields; the others carry junk that must never reach the port.
    task automatic drive_row(input vec_t v);
        req_a = v.req;
        for (int k = 0; k < NC; k++) begin
            if (k == v.ch) begin
                we[k] = v.we; sel[k] = v.sel; adr[k] = v.adr; wdata[k] = v.wd;
            end else begin
                we[k] = ~v.we; sel[k] = 4'hA; adr[k] = 32'hFFFF_0000 + k; wdata[k] = 32'hBAD0_0000 + k;
            end
        end
        mem_busy  = v.busy;
        mem_rdata = v.rd;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive_row(tbl[i]);
            @(negedge clk);
            chk($sformatf("row%0d_read", i),  rd_a,   tbl[i].e_rd);
            chk($sformatf("row%0d_write", i), wr_a,   tbl[i].e_wr);
            chk($sformatf("row%0d_sel", i),   msel_a, tbl[i].e_sel);
            chk($sformatf("row%0d_adr", i),   madr_a, tbl[i].e_adr);
            chk($sformatf("row%0d_wdata", i), mwd_a,  tbl[i].e_wd);
            chk($sformatf("row%0d_ack", i),   ack_a,  tbl[i].e_ack);
            chk($sformatf("row%0d_gid", i),   gid_a,  tbl[i].e_gid);
            @(posedge clk);
            #1;
        end
    endtask

    int rr_exp [5];
    int n;

    initial begin
        //          req   ch we sel    adr           wd            busy rd            rd wr sel   adr           wd            ack   gid
        tbl[0]  = '{3'b001, 0, 0, 4'hF, 32'h100,  32'h0,        0, 32'h0,        0, 0, 4'h0, 32'h0,    32'h0,        3'b000, 2'd0};
        tbl[1]  = '{3'b000, 0, 0, 4'hF, 32'h100,  32'h0,        0, 32'hDEADBEEF, 1, 0, 4'hF, 32'h100,  32'h0,        3'b000, 2'd0};
        tbl[2]  = '{3'b000, 0, 0, 4'hF, 32'h100,  32'h0,        0, 32'h0,        0, 0, 4'h0, 32'h0,    32'h0,        3'b001, 2'd0};
        tbl[3]  = '{3'b000, 0, 0, 4'hF, 32'h100,  32'h0,        0, 32'h0,        0, 0, 4'h0, 32'h0,    32'h0,        3'b000, 2'd0};
        tbl[4]  = '{3'b010, 1, 1, 4'h3, 32'h2004, 32'h12345678, 1, 32'h0,        0, 0, 4'h0, 32'h0,    32'h0,        3'b000, 2'd0};
        tbl[5]  = '{3'b000, 1, 1, 4'h3, 32'h2004, 32'h12345678, 1, 32'h55555555, 0, 1, 4'h3, 32'h2004, 32'h12345678, 3'b000, 2'd1};
        tbl[6]  = '{3'b000, 1, 1, 4'h3, 32'h2004, 32'h12345678, 1, 32'h55555555, 0, 1, 4'h3, 32'h2004, 32'h12345678, 3'b000, 2'd1};
        tbl[7]  = '{3'b000, 1, 1, 4'h3, 32'h2004, 32'h12345678, 1, 32'h55555555, 0, 1, 4'h3, 32'h2004, 32'h12345678, 3'b000, 2'd1};
        tbl[8]  = '{3'b000, 1, 1, 4'h3, 32'h2004, 32'h12345678, 0, 32'h55555555, 0, 1, 4'h3, 32'h2004, 32'h12345678, 3'b000, 2'd1};
        tbl[9]  = '{3'b000, 1, 1, 4'h3, 32'h2004, 32'h12345678, 0, 32'h0,        0, 0, 4'h0, 32'h0,    32'h0,        3'b010, 2'd1};
        tbl[10] = '{3'b010, 1, 0, 4'h0, 32'h300,  32'h0,        0, 32'h0,        0, 0, 4'h0, 32'h0,    32'h0,        3'b000, 2'd1};
        tbl[11] = '{3'b000, 1, 0, 4'h0, 32'h999,  32'hAAAA,     1, 32'h0,        1, 0, 4'h0, 32'h300,  32'h0,        3'b000, 2'd1};
        tbl[12] = '{3'b000, 1, 0, 4'h0, 32'h999,  32'hAAAA,     0, 32'hCAFEF00D, 1, 0, 4'h0, 32'h300,  32'h0,        3'b000, 2'd1};
        tbl[13] = '{3'b000, 1, 0, 4'h0, 32'h999,  32'hAAAA,     0, 32'h0,        0, 0, 4'h0, 32'h0,    32'h0,        3'b010, 2'd1};
        tbl[14] = '{3'b000, 1, 0, 4'h0, 32'h999,  32'hAAAA,     0, 32'h0,        0, 0, 4'h0, 32'h0,    32'h0,        3'b000, 2'd1};
        rr_exp = '{0, 1, 2, 0, 1};

        nRst = 1'b0; req_a = '0; req_b = '0; we = '0; sel = '0; adr = '0; wdata = '0;
        mem_busy = 1'b0; mem_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_gid", gid_a, 2'd0);
        chk("rst_ack", ack_a, 3'b000);
        chk("rst_rdata", (rdata_a[0] | rdata_a[1] | rdata_a[2]), 32'h0);
        chk("rst_cmd", {rd_a, wr_a, msel_a, madr_a}, 0);
        nRst = 1'b1;
        @(posedge clk);
        #1;

        // Single read on ch0, then a wait-stated write on ch1.
        run_rows(0, 3);
        chk("rd_hold_ch0", rdata_a[0], 32'hDEADBEEF);
        run_rows(4, 9);
        chk("wr_keeps_ch1", rdata_a[1], 32'h0);
        chk("wr_keeps_ch0", rdata_a[0], 32'hDEADBEEF);
        // Request withdrawn and address changed after the grant.
        run_rows(10, 14);
        chk("withdrawn_rdata_ch1", rdata_a[1], 32'hCAFEF00D);

        // Reset while a read is stalled on the port.
        req_a = 3'b001; adr = '0; adr[0] = 32'h40; we = '0; mem_busy = 1'b1;
        @(posedge clk);
        #1;
        req_a = '0;
        @(negedge clk);
        chk("midrst_read_before", rd_a, 1'b1);
        #2;
        nRst = 1'b0;
        #1;
        chk("midrst_read_drop", rd_a, 1'b0);
        chk("midrst_no_ack", ack_a, 3'b000);
        @(posedge clk);
        @(negedge clk);
        chk("midrst_ack_held", ack_a, 3'b000);
        chk("midrst_rdata0", rdata_a[0], 32'h0);
        chk("midrst_rdata1", rdata_a[1], 32'h0);
        chk("midrst_gid", gid_a, 2'd0);
        chk("midrst_cmd", {rd_a, wr_a, msel_a, madr_a, mwd_a}, 0);
        nRst = 1'b1;
        mem_busy = 1'b0;
        @(posedge clk);
        #1;

        // Round-robin with all three channels requesting continuously.
        req_a = 3'b111;
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            @(negedge clk);
            if (ack_a != 3'b000) begin
                chk($sformatf("rr_ack%0d", n), ack_a, 3'b001 << rr_exp[n]);
                chk($sformatf("rr_gid%0d", n), gid_a, rr_exp[n]);
                n++;
            end
        end
        req_a = '0;
        chk("rr_grant_count", n, 5);
        repeat (4) @(posedge clk);
        #1;

        // Fixed priority: ch0 and ch2 requesting, ch0 must win every time.
        req_b = 3'b101;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (ack_b != 3'b000) begin
                chk($sformatf("fp_ack%0d", n), ack_b, 3'b001);
                chk($sformatf("fp_gid%0d", n), gid_b, 2'd0);
                n++;
            end
        end
        req_b = '0;
        chk("fp_grant_count", n, 4);
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
